// File: rtl/audio_i2s_tx.sv
// Philips I2S transmitter: captures one stereo pair per frame, applies a
// frame-stepped soft-mute ramp and shifts the pair out MSB first.
module audio_i2s_tx #(
  parameter int unsigned IW        = 16,
  parameter int unsigned BCLK_HALF = 17
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [IW-1:0] snd_l_in,
  input  logic [IW-1:0] snd_r_in,
  input  logic          mute,
  output logic          i2s_bclk,
  output logic          i2s_lrck,
  output logic          i2s_sdata,
  output logic          frame_start,
  output logic          muted
);

  localparam int unsigned FW = 2 * IW;
  localparam int unsigned BW = $clog2(FW);
  localparam int unsigned CW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int unsigned AW = $clog2(IW + 1);

  typedef enum logic [1:0] {
    ST_PLAY,
    ST_DOWN,
    ST_MUTED,
    ST_UP
  } state_t;

  logic [CW-1:0] bclk_cnt;
  logic [BW-1:0] bit_cnt;
  logic [FW-1:0] sreg;
  logic [AW-1:0] atten;
  state_t        state;

  logic          bclk_tc_c;
  logic          bclk_fall_c;
  logic [BW-1:0] bit_nxt_c;
  logic          frame_edge_c;
  logic [AW-1:0] atten_dn_c;
  logic [AW-1:0] atten_up_c;
  logic [AW-1:0] atten_nxt_c;
  state_t        state_nxt_c;

  // Arithmetic attenuation; full attenuation forces a true zero.
  function automatic logic [IW-1:0] att(input logic [IW-1:0] x, input logic [AW-1:0] a);
    logic signed [IW-1:0] s;
    s = signed'(x);
    if (a >= AW'(IW)) begin
      return '0;
    end
    return IW'(s >>> a);
  endfunction

  assign bclk_tc_c    = (bclk_cnt == CW'(BCLK_HALF - 1));
  assign bclk_fall_c  = bclk_tc_c & i2s_bclk;
  assign bit_nxt_c    = (bit_cnt == BW'(FW - 1)) ? '0 : bit_cnt + BW'(1);
  assign frame_edge_c = bclk_fall_c && (bit_nxt_c == '0);
  assign atten_dn_c   = atten + AW'(1);
  assign atten_up_c   = atten - AW'(1);

  // Soft-mute ramp: one attenuation step per frame, reversible mid-ramp.
  always_comb begin
    atten_nxt_c = atten;
    state_nxt_c = state;
    case (state)
      ST_PLAY: begin
        if (mute) begin
          atten_nxt_c = atten_dn_c;
          state_nxt_c = (atten_dn_c == AW'(IW)) ? ST_MUTED : ST_DOWN;
        end
      end
      ST_MUTED: begin
        if (!mute) begin
          atten_nxt_c = atten_up_c;
          state_nxt_c = (atten_up_c == '0) ? ST_PLAY : ST_UP;
        end
      end
      default: begin
        if (mute) begin
          atten_nxt_c = atten_dn_c;
          state_nxt_c = (atten_dn_c == AW'(IW)) ? ST_MUTED : ST_DOWN;
        end else begin
          atten_nxt_c = atten_up_c;
          state_nxt_c = (atten_up_c == '0) ? ST_PLAY : ST_UP;
        end
      end
    endcase
  end

  // Bit clock, serialiser, frame capture and mute state; serial state moves
  // only on BCLK falling edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_cnt    <= '0;
      bit_cnt     <= BW'(FW - 1);
      sreg        <= '0;
      atten       <= AW'(IW);
      state       <= ST_MUTED;
      i2s_bclk    <= 1'b0;
      i2s_lrck    <= 1'b0;
      i2s_sdata   <= 1'b0;
      frame_start <= 1'b0;
      muted       <= 1'b1;
    end else begin
      if (bclk_tc_c) begin
        bclk_cnt <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        bclk_cnt <= bclk_cnt + CW'(1);
      end
      frame_start <= frame_edge_c;
      if (bclk_fall_c) begin
        bit_cnt   <= bit_nxt_c;
        i2s_lrck  <= (bit_nxt_c >= BW'(IW));
        // At slot 0 the MSB is the previous frame's right LSB (one-bit delay).
        i2s_sdata <= sreg[FW-1];
        if (frame_edge_c) begin
          sreg  <= {att(snd_l_in, atten), att(snd_r_in, atten)};
          atten <= atten_nxt_c;
          state <= state_nxt_c;
          muted <= (atten_nxt_c == AW'(IW));
        end else begin
          sreg <= {sreg[FW-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: power-up ramp, bit order, soft mute with
// reversal, negative attenuation and asynchronous reset mid-frame.
module tb_audio_i2s_tx;

  localparam int unsigned IW = 16;
  localparam int unsigned BH = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [IW-1:0] snd_l_in;
  logic [IW-1:0] snd_r_in;
  logic          mute;
  logic          i2s_bclk;
  logic          i2s_lrck;
  logic          i2s_sdata;
  logic          frame_start;
  logic          muted;

  audio_i2s_tx #(.IW(IW), .BCLK_HALF(BH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .snd_l_in   (snd_l_in),
    .snd_r_in   (snd_r_in),
    .mute       (mute),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrck   (i2s_lrck),
    .i2s_sdata  (i2s_sdata),
    .frame_start(frame_start),
    .muted      (muted)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_fs = -1;
  int   stable_bad = 0;
  int   fs_bad = 0;
  int   lrck_bad = 0;
  logic prev_bclk, prev_lrck, prev_sdata;
  logic fell, rose;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] att_ref(input logic [IW-1:0] x, input int a);
    logic signed [IW-1:0] s;
    s = x;
    if (a >= 16) return '0;
    return 16'(s >>> a);
  endfunction

  task automatic sync_prev();
    prev_bclk  = i2s_bclk;
    prev_lrck  = i2s_lrck;
    prev_sdata = i2s_sdata;
  endtask

  // One clk, sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    fell = prev_bclk && !i2s_bclk;
    rose = !prev_bclk && i2s_bclk;
    if (!fell && (i2s_lrck !== prev_lrck || i2s_sdata !== prev_sdata || frame_start))
      stable_bad++;
    if (frame_start) begin
      if (last_fs >= 0 && (cyc - last_fs) != 128) fs_bad++;
      last_fs = cyc;
    end
    sync_prev();
  endtask

  task automatic next_fall();
    for (int i = 0; i < 64; i++) begin
      tick();
      if (fell) return;
    end
    check("fall_timeout", 32'd1, 32'd0);
  endtask

  // Starting at a capture clk, collect that frame's word; ends at the next capture.
  task automatic run_frame(input logic [IW-1:0] l, input logic [IW-1:0] r, input int a,
                           input string tag);
    logic [31:0] w;
    int slot;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      next_fall();
      w = {w[30:0], i2s_sdata};
      slot = (i + 1) % 32;
      if (i2s_lrck !== (slot >= 16)) lrck_bad++;
    end
    check({tag, "_fs"}, 32'(frame_start), 32'd1);
    check(tag, w, {att_ref(l, a), att_ref(r, a)});
  endtask

  // Count clks from reset release to the first BCLK falling edge.
  task automatic first_fall(input string tag);
    int n, rise_n;
    logic pre_m;
    n = 0; rise_n = 0; pre_m = 1'b0;
    sync_prev();
    last_fs = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (rose && rise_n == 0) rise_n = n;
      if (fell) break;
      pre_m = muted;
    end
    check({tag, "_rise_clk"}, 32'(rise_n), 32'd2);
    check({tag, "_fall_clk"}, 32'(n), 32'd4);
    check({tag, "_fs0"}, 32'(frame_start), 32'd1);
    check({tag, "_muted_pre"}, 32'(pre_m), 32'd1);
    check({tag, "_muted_post"}, 32'(muted), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc %0d exp finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    mute     = 1'b0;
    snd_l_in = 16'h4000;
    snd_r_in = 16'hC000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bclk", 32'(i2s_bclk), 32'd0);
    check("rst_lrck", 32'(i2s_lrck), 32'd0);
    check("rst_sdata", 32'(i2s_sdata), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_muted", 32'(muted), 32'd1);

    // Power-up ramp from full attenuation.
    reset_n = 1'b1;
    first_fall("pwr");
    for (int k = 0; k < 18; k++)
      run_frame(16'h4000, 16'hC000, (k <= 16) ? 16 - k : 0, $sformatf("pwrup%0d", k));

    // Bit order: frame 19 carries A5C3 / 0F0F unattenuated.
    snd_l_in = 16'hA5C3;
    snd_r_in = 16'h0F0F;
    run_frame(16'h4000, 16'hC000, 0, "play18");
    run_frame(16'hA5C3, 16'h0F0F, 0, "bitorder");

    // Soft mute down to full mute; negative samples through the ramp.
    mute     = 1'b1;
    snd_l_in = 16'hFFFF;
    snd_r_in = 16'h8000;
    run_frame(16'hA5C3, 16'h0F0F, 0, "bitorder2");
    run_frame(16'hFFFF, 16'h8000, 0, "dn0");
    for (int a = 1; a <= 16; a++)
      run_frame(16'hFFFF, 16'h8000, a, $sformatf("dn%0d", a));
    check("muted_full", 32'(muted), 32'd1);
    run_frame(16'hFFFF, 16'h8000, 16, "hold");

    // Release from full mute: ramp back up over 16 frames.
    mute     = 1'b0;
    snd_l_in = 16'h8000;
    snd_r_in = 16'hFFFF;
    run_frame(16'hFFFF, 16'h8000, 16, "rel39");
    run_frame(16'h8000, 16'hFFFF, 16, "rel40");
    check("muted_rel", 32'(muted), 32'd0);
    for (int a = 15; a >= 0; a--)
      run_frame(16'h8000, 16'hFFFF, a, $sformatf("up%0d", a));

    // Mute again and reverse at attenuation 5.
    mute = 1'b1;
    run_frame(16'h8000, 16'hFFFF, 0, "rv57");
    run_frame(16'h8000, 16'hFFFF, 0, "rv58");
    for (int a = 1; a <= 3; a++)
      run_frame(16'h8000, 16'hFFFF, a, $sformatf("rvdn%0d", a));
    mute = 1'b0;
    run_frame(16'h8000, 16'hFFFF, 4, "rvdn4");
    run_frame(16'h8000, 16'hFFFF, 5, "rvdn5");
    for (int a = 4; a >= 0; a--)
      run_frame(16'h8000, 16'hFFFF, a, $sformatf("rvup%0d", a));
    check("muted_play", 32'(muted), 32'd0);
    run_frame(16'h8000, 16'hFFFF, 0, "play69");

    // Asynchronous reset between clk edges at slot 9 with bclk high.
    repeat (9) next_fall();
    tick();
    tick();
    check("pre_rst_bclk", 32'(i2s_bclk), 32'd1);
    check("pre_rst_muted", 32'(muted), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_bclk", 32'(i2s_bclk), 32'd0);
    check("arst_lrck", 32'(i2s_lrck), 32'd0);
    check("arst_sdata", 32'(i2s_sdata), 32'd0);
    check("arst_muted", 32'(muted), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    first_fall("rst2");
    run_frame(16'h8000, 16'hFFFF, 16, "rst2_f0");
    run_frame(16'h8000, 16'hFFFF, 15, "rst2_f1");

    check("lrck_slots", 32'(lrck_bad), 32'd0);
    check("change_on_fall", 32'(stable_bad), 32'd0);
    check("fs_period", 32'(fs_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
